spike_weight_accumulator: RTL

Synaptic input stage feeding the neuron potential adders. Accepts spike events, identified by source neuron ID, through a valid/ready handshake and buffers them in a small FIFO. For each event it adds a programmable per-(source, target) weight into one accumulator per local neuron. At each timestep boundary it drains pending events, publishes the accumulated sums as the `input_weight` values for the adders, and clears for the next step.

---
 rtl/spike_weight_accumulator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spike_weight_accumulator.sv
// Purpose: buffers spike IDs in a small FIFO, adds per-(source,target) weights into per-neuron accumulators, publishes sums each timestep.
// Latency: spike accepted at edge N is accumulated at edge N+1; publish is 2 cycles after timestep_start plus one cycle per queued spike.
// Backpressure: spike_ready drops while the FIFO is full or a timestep is being closed (DRAIN/PUBLISH).
// Optional build macro SPIKE_ACC_SATURATE_EN: saturating accumulation instead of two's-complement wrap.
module spike_weight_accumulator #(
   parameter int NUM_NEURONS = 4,
   parameter int NUM_SOURCES = 16,
   parameter int SRC_W       = 4,
   parameter int FIFO_DEPTH  = 4,
   localparam int NRN_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      spike_valid,
   input  logic [SRC_W-1:0]          spike_src,
   output logic                      spike_ready,
   input  logic                      wr_en,
   input  logic [SRC_W-1:0]          wr_src,
   input  logic [NRN_W-1:0]          wr_neuron,
   input  logic [31:0]               wr_data,
   input  logic                      timestep_start,
   output logic [32*NUM_NEURONS-1:0] input_weight,
   output logic                      weights_valid,
   output logic                      timestep_overrun,
   output logic                      spike_dropped
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      PUBLISH
   } state_t;

   state_t state;

   logic [SRC_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;

   logic signed [31:0] weight   [NUM_SOURCES][NUM_NEURONS];
   logic signed [31:0] acc      [NUM_NEURONS];
   logic signed [31:0] acc_next [NUM_NEURONS];

   logic              push;
   logic              pop;
   logic [SRC_W-1:0]  pop_id;
   logic              pop_in_range;
   logic [SRC_W-1:0]  pop_row;
   logic              wr_ok;

   // Ready is held low during reset so every output reads 0 while it is asserted.
   assign spike_ready  = !reset && (state == IDLE) && (fifo_cnt < CNT_W'(FIFO_DEPTH));
   assign push         = spike_valid && spike_ready;
   assign pop          = ((state == IDLE) || (state == DRAIN)) && (fifo_cnt != '0);
   assign pop_id       = fifo_mem[rd_ptr];
   assign pop_in_range = (32'(pop_id) < NUM_SOURCES);
   // Out-of-range IDs read row 0 but the result is discarded; keeps the table read in bounds.
   assign pop_row      = pop_in_range ? pop_id : '0;
   assign wr_ok        = wr_en && (32'(wr_src) < NUM_SOURCES) && (32'(wr_neuron) < NUM_NEURONS);

   // FIFO storage: data needs no reset, emptiness is defined by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= spike_src;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Weight table writes; an accumulate in the same cycle sees the pre-write value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SOURCES; s++) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
               weight[s][n] <= '0;
            end
         end
      end else if (wr_ok) begin
         weight[wr_src][wr_neuron] <= wr_data;
      end
   end

   // Next accumulator values for the popped row, all neurons in parallel.
   always_comb begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
         acc_next[n] = acc[n] + weight[pop_row][n];
`ifdef SPIKE_ACC_SATURATE_EN
         // Same-sign operands producing a different-sign result is an overflow; clamp toward the operand sign.
         if ((acc[n][31] == weight[pop_row][n][31]) && (acc_next[n][31] != acc[n][31])) begin
            acc_next[n] = acc[n][31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
         end
`endif
      end
   end

   // Accumulators: add on in-range pops, clear when the step is published.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            acc[n] <= '0;
         end
      end else if (state == PUBLISH) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            acc[n] <= '0;
         end
      end else if (pop && pop_in_range) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            acc[n] <= acc_next[n];
         end
      end
   end

   // Timestep FSM with registered publish data and pulse outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         input_weight     <= '0;
         weights_valid    <= 1'b0;
         timestep_overrun <= 1'b0;
         spike_dropped    <= 1'b0;
      end else begin
         weights_valid    <= 1'b0;
         timestep_overrun <= timestep_start && (state != IDLE);
         spike_dropped    <= pop && !pop_in_range;
         case (state)
            IDLE: begin
               if (timestep_start) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Pushes are blocked here, so an empty FIFO means nothing is left to pop.
               if (fifo_cnt == '0) begin
                  state <= PUBLISH;
               end
            end
            PUBLISH: begin
               for (int n = 0; n < NUM_NEURONS; n++) begin
                  input_weight[32*n +: 32] <= acc[n];
               end
               weights_valid <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
